uart_line_editor: RTL and testbench

Line-editing stage between the UART receiver and the UART transmit buffer. It consumes received bytes, echoes them back to the terminal with backspace handling, and assembles printable characters into a line buffer. On carriage return it presents the completed line to a downstream command consumer through a random-access read port and a done/ack handshake.

---
 rtl/uart_line_pkg.sv | 27 ++
 rtl/uart_line_ram.sv | 32 +++
 rtl/uart_line_editor.sv | 163 ++++++++++++++++
 tb/tb_uart_line_editor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_line_pkg.sv
// Shared constants for the UART line editor: ASCII codes, FSM state encodings
// and a printable-character helper.
package uart_line_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_BEL = 8'h07;

    localparam logic [STATE_W-1:0] ST_EDIT  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ECHO1 = 3'd1;
    localparam logic [STATE_W-1:0] ST_BS1   = 3'd2;
    localparam logic [STATE_W-1:0] ST_BS2   = 3'd3;
    localparam logic [STATE_W-1:0] ST_BS3   = 3'd4;
    localparam logic [STATE_W-1:0] ST_CR1   = 3'd5;
    localparam logic [STATE_W-1:0] ST_CR2   = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd7;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line buffer storage: one write port and one registered read port.
module uart_line_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register resets so the read port starts at a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_line_editor.sv
// UART line editor: edge-detects received bytes, echoes with backspace handling,
// assembles a line and hands it to a consumer with a done/ack handshake.
module uart_line_editor
    import uart_line_pkg::*;
#(
    parameter int unsigned LINE_LEN = 64,
    parameter int unsigned ECHO     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_valid,
    output logic [7:0]                  echo_data,
    output logic                        echo_valid,
    input  logic                        echo_ready,
    input  logic [$clog2(LINE_LEN)-1:0] line_addr,
    output logic [7:0]                  line_data,
    output logic [$clog2(LINE_LEN):0]   line_len,
    output logic                        line_done,
    input  logic                        line_ack,
    output logic                        dropped
);

    localparam int unsigned AW = $clog2(LINE_LEN);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(LINE_LEN);

    logic [STATE_W-1:0] state, state_d;
    logic [LW-1:0]      len_d;
    logic [7:0]         echo_data_d;
    logic               echo_valid_d, done_d, dropped_d;
    logic               rx_q, rx_rise, hs, we;

    assign rx_rise = rx_valid && !rx_q;
    assign hs      = echo_valid && echo_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EDIT;
            rx_q       <= 1'b1;
            line_len   <= '0;
            echo_data  <= 8'h00;
            echo_valid <= 1'b0;
            line_done  <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_d;
            rx_q       <= rx_valid;
            line_len   <= len_d;
            echo_data  <= echo_data_d;
            echo_valid <= echo_valid_d;
            line_done  <= done_d;
            dropped    <= dropped_d;
        end
    end

    always_comb begin
        state_d      = state;
        len_d        = line_len;
        echo_data_d  = echo_data;
        echo_valid_d = echo_valid;
        done_d       = line_done;
        dropped_d    = dropped;
        we           = 1'b0;

        // Any edge outside EDIT is lost; a line_ack in DONE below overrides this.
        if (rx_rise && (state != ST_EDIT)) begin
            dropped_d = 1'b1;
        end

        case (state)
            ST_EDIT: begin
                if (rx_rise) begin
                    if (is_printable(rx_byte)) begin
                        if (line_len < LEN_MAX) begin
                            we    = 1'b1;
                            len_d = line_len + LW'(1);
                        end else begin
                            dropped_d = 1'b1;
                        end
                        if (ECHO != 0) begin
                            echo_valid_d = 1'b1;
                            echo_data_d  = (line_len < LEN_MAX) ? rx_byte : ASCII_BEL;
                            state_d      = ST_ECHO1;
                        end
                    end else if ((rx_byte == ASCII_BS) || (rx_byte == ASCII_DEL)) begin
                        if (line_len != '0) begin
                            len_d = line_len - LW'(1);
                            if (ECHO != 0) begin
                                echo_valid_d = 1'b1;
                                echo_data_d  = ASCII_BS;
                                state_d      = ST_BS1;
                            end
                        end
                    end else if (rx_byte == ASCII_CR) begin
                        if (ECHO != 0) begin
                            echo_valid_d = 1'b1;
                            echo_data_d  = ASCII_CR;
                            state_d      = ST_CR1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_ECHO1, ST_BS3: begin
                if (hs) begin
                    echo_valid_d = 1'b0;
                    state_d      = ST_EDIT;
                end
            end
            ST_BS1: begin
                if (hs) begin
                    echo_data_d = ASCII_SP;
                    state_d     = ST_BS2;
                end
            end
            ST_BS2: begin
                if (hs) begin
                    echo_data_d = ASCII_BS;
                    state_d     = ST_BS3;
                end
            end
            ST_CR1: begin
                if (hs) begin
                    echo_data_d = ASCII_LF;
                    state_d     = ST_CR2;
                end
            end
            ST_CR2: begin
                if (hs) begin
                    echo_valid_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (line_ack) begin
                    done_d    = 1'b0;
                    len_d     = '0;
                    dropped_d = 1'b0;
                    state_d   = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    uart_line_ram #(
        .DEPTH(LINE_LEN),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(line_len[AW-1:0]),
        .wdata(rx_byte),
        .raddr(line_addr),
        .rdata(line_data)
    );

endmodule

// File: tb/tb_uart_line_editor.sv
// Scoreboard bench for uart_line_editor: echo and completed-line expectations are
// queued by the stimulus and checked by an independent monitor.
module tb_uart_line_editor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] echo_data;
    logic       echo_valid;
    logic       echo_ready = 1'b1;
    logic [1:0] line_addr = 2'd0;
    logic [7:0] line_data;
    logic [2:0] line_len;
    logic       line_done;
    logic       line_ack = 1'b0;
    logic       dropped;

    logic [7:0] rx_byte0 = 8'h00;
    logic       rx_valid0 = 1'b0;
    logic [7:0] echo_data0;
    logic       echo_valid0;
    logic [1:0] line_addr0 = 2'd0;
    logic [7:0] line_data0;
    logic [2:0] line_len0;
    logic       line_done0;
    logic       dropped0;

    typedef struct {
        int unsigned len;
        bit          drop;
    } line_t;

    logic [7:0] echo_q[$];
    line_t      line_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         done_prev = 1'b0;
    bit         seen0 = 1'b0;
    logic [7:0] mon_exp;
    line_t      mon_line;

    always #5 clk = ~clk;

    uart_line_editor #(.LINE_LEN(4), .ECHO(1)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready),
        .line_addr(line_addr), .line_data(line_data), .line_len(line_len),
        .line_done(line_done), .line_ack(line_ack), .dropped(dropped)
    );

    uart_line_editor #(.LINE_LEN(4), .ECHO(0)) dut0 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte0), .rx_valid(rx_valid0),
        .echo_data(echo_data0), .echo_valid(echo_valid0), .echo_ready(1'b1),
        .line_addr(line_addr0), .line_data(line_data0), .line_len(line_len0),
        .line_done(line_done0), .line_ack(1'b0), .dropped(dropped0)
    );

    // Monitor: compares every echo handshake and every completed line against the queues.
    always @(negedge clk) begin
        if (!rst && echo_valid && echo_ready) begin
            checks++;
            if (echo_q.size() == 0) begin
                errors++;
                $display("FAIL echo_unexpected actual=%02h required=none", echo_data);
            end else begin
                mon_exp = echo_q.pop_front();
                if (echo_data !== mon_exp) begin
                    errors++;
                    $display("FAIL echo_byte actual=%02h required=%02h", echo_data, mon_exp);
                end
            end
        end
        if (line_done && !done_prev) begin
            checks++;
            if (line_q.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected actual_len=%0d required=none", line_len);
            end else begin
                mon_line = line_q.pop_front();
                if ((line_len !== 3'(mon_line.len)) || (dropped !== mon_line.drop)) begin
                    errors++;
                    $display("FAIL line_result actual len=%0d dropped=%0b required len=%0d dropped=%0b",
                             line_len, dropped, mon_line.len, mon_line.drop);
                end
            end
        end
        done_prev = line_done;
        if (echo_valid0) seen0 = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_echo_idle();
        for (int i = 0; i < 100 && echo_valid; i++) tick();
        if (echo_valid) check("echo_idle_timeout", 32'(echo_valid), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        wait_echo_idle();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !line_done; i++) tick();
        check("line_done_wait", 32'(line_done), 32'd1);
    endtask

    task automatic read_check(input logic [1:0] a, input logic [7:0] exp);
        line_addr = a;
        tick();
        check("line_data", 32'(line_data), 32'(exp));
    endtask

    task automatic ack_line();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        check("ack_done", 32'(line_done), 32'd0);
        check("ack_len", 32'(line_len), 32'd0);
        check("ack_dropped", 32'(dropped), 32'd0);
    endtask

    task automatic push_echo(input logic [7:0] b);
        echo_q.push_back(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_echo_valid"}, 32'(echo_valid), 32'd0);
        check({tag, "_echo_data"}, 32'(echo_data), 32'd0);
        check({tag, "_line_done"}, 32'(line_done), 32'd0);
        check({tag, "_line_len"}, 32'(line_len), 32'd0);
        check({tag, "_dropped"}, 32'(dropped), 32'd0);
        check({tag, "_line_data"}, 32'(line_data), 32'd0);
    endtask

    initial begin
        bit stable;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic line "ab" CR
        push_echo(8'h61); push_echo(8'h62); push_echo(8'h0D); push_echo(8'h0A);
        line_q.push_back('{len: 2, drop: 1'b0});
        send(8'h61); send(8'h62); send(8'h0D);
        wait_done();
        read_check(2'd0, 8'h61);
        read_check(2'd1, 8'h62);
        ack_line();

        // Backspace: BS at empty line is silent, DEL after "abc" erases 'c'
        send(8'h08);
        check("bs_empty_len", 32'(line_len), 32'd0);
        push_echo(8'h61); push_echo(8'h62); push_echo(8'h63);
        push_echo(8'h08); push_echo(8'h20); push_echo(8'h08);
        push_echo(8'h64); push_echo(8'h0D); push_echo(8'h0A);
        line_q.push_back('{len: 3, drop: 1'b0});
        send(8'h61); send(8'h62); send(8'h63); send(8'h7F);
        check("bs_len", 32'(line_len), 32'd2);
        send(8'h64); send(8'h0D);
        wait_done();
        read_check(2'd0, 8'h61);
        read_check(2'd1, 8'h62);
        read_check(2'd2, 8'h64);
        ack_line();

        // Overflow: fifth byte rings the bell and is not stored
        push_echo(8'h61); push_echo(8'h62); push_echo(8'h63); push_echo(8'h64);
        push_echo(8'h07); push_echo(8'h0D); push_echo(8'h0A);
        line_q.push_back('{len: 4, drop: 1'b1});
        send(8'h61); send(8'h62); send(8'h63); send(8'h64); send(8'h65);
        check("ovf_len", 32'(line_len), 32'd4);
        check("ovf_dropped", 32'(dropped), 32'd1);
        send(8'h0D);
        wait_done();
        read_check(2'd3, 8'h64);
        ack_line();

        // Echo backpressure with a second edge during the stall
        echo_ready = 1'b0;
        push_echo(8'h78);
        rx_byte = 8'h78; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin rx_byte = 8'h79; rx_valid = 1'b1; end
            if (i == 6) rx_valid = 1'b0;
            if (!(echo_valid === 1'b1 && echo_data === 8'h78)) stable = 1'b0;
            tick();
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_dropped", 32'(dropped), 32'd1);
        check("stall_len", 32'(line_len), 32'd1);
        echo_ready = 1'b1;
        wait_echo_idle();
        push_echo(8'h0D); push_echo(8'h0A);
        line_q.push_back('{len: 1, drop: 1'b1});
        send(8'h0D);
        wait_done();
        ack_line();

        // Edge coinciding with the final echo handshake is dropped
        echo_ready = 1'b0;
        push_echo(8'h7A);
        rx_byte = 8'h7A; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        echo_ready = 1'b1;
        rx_byte = 8'h71; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        check("edge_hs_dropped", 32'(dropped), 32'd1);
        check("edge_hs_len", 32'(line_len), 32'd1);
        check("edge_hs_echo_idle", 32'(echo_valid), 32'd0);
        push_echo(8'h0D); push_echo(8'h0A);
        line_q.push_back('{len: 1, drop: 1'b1});
        send(8'h0D);
        wait_done();
        read_check(2'd0, 8'h7A);
        ack_line();

        // Level input held across reset release
        rx_byte = 8'h6B; rx_valid = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("level_len", 32'(line_len), 32'd0);
        check("level_echo", 32'(echo_valid), 32'd0);
        rx_valid = 1'b0;
        tick();
        push_echo(8'h6B);
        send(8'h6B);
        check("level_then_edge_len", 32'(line_len), 32'd1);

        // Reset while in BS2
        echo_ready = 1'b0;
        rx_byte = 8'h08; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        push_echo(8'h08);
        echo_ready = 1'b1;
        tick();
        echo_ready = 1'b0;
        check("bs2_data", 32'(echo_data), 32'h20);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        echo_ready = 1'b1;
        tick();

        // ECHO=0 instance: "hi" CR, done one cycle after the CR edge
        rx_byte0 = 8'h68; rx_valid0 = 1'b1; tick(); rx_valid0 = 1'b0; tick();
        rx_byte0 = 8'h69; rx_valid0 = 1'b1; tick(); rx_valid0 = 1'b0; tick();
        check("e0_len", 32'(line_len0), 32'd2);
        rx_byte0 = 8'h0D; rx_valid0 = 1'b1;
        check("e0_done_before", 32'(line_done0), 32'd0);
        tick();
        rx_valid0 = 1'b0;
        check("e0_done_after", 32'(line_done0), 32'd1);
        line_addr0 = 2'd1;
        tick();
        check("e0_line_data", 32'(line_data0), 32'h69);
        check("e0_dropped", 32'(dropped0), 32'd0);
        check("e0_echo_never", 32'(seen0), 32'd0);

        tick(); tick();
        check("echo_queue_empty", 32'(echo_q.size()), 32'd0);
        check("line_queue_empty", 32'(line_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
